// File: rtl/digit_entry_ctrl.sv
// ---------------------------------------------------------------------------
// digit_entry_ctrl
//
// Button-driven numeric entry controller for the ATM front panel. Debounced
// button levels are edge-detected, and each press edits one BCD digit of a
// packed register under a cursor. The enter button captures the register
// into commit_o. The captured value is then held under a valid/ready
// handshake until downstream logic accepts it.
//
// Optional build macro: DIGIT_ENTRY_AUTOREPEAT_EN
//   When defined, holding increment or decrement generates repeat events:
//   the first comes REPEAT_DELAY cycles after the press, and the following
//   ones every REPEAT_PERIOD cycles. When undefined, no repeat logic is
//   built.
//
// Parameters:
//   NUM_DIGITS      number of 4-bit digits (1..16)
//   DIGIT_MAX       largest legal digit value (1..15)
//   WRAP            0 = inc/dec saturate, 1 = inc/dec wrap DIGIT_MAX<->0
//   CLEAR_ON_COMMIT 1 = digits and cursor clear when the handshake completes
//   SEL_W           cursor width (derived, do not override)
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   btn_i     debounced levels: [0] left, [1] right, [2] inc, [3] dec, [4] enter
//   ready_i   downstream accepts the committed value
//   data_o    live edit register, digit k at [4k+3:4k]
//   sel_o     cursor position, 0 = least-significant digit
//   commit_o  value captured on enter
//   valid_o   commit_o is valid
//   busy_o    high while waiting for the handshake (HOLD)
// ---------------------------------------------------------------------------
module digit_entry_ctrl #(
  parameter int NUM_DIGITS      = 8,
  parameter int DIGIT_MAX       = 9,
  parameter int WRAP            = 0,
  parameter int CLEAR_ON_COMMIT = 1,
  parameter int SEL_W           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              btn_i,
  input  logic                    ready_i,
  output logic [4*NUM_DIGITS-1:0] data_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic [4*NUM_DIGITS-1:0] commit_o,
  output logic                    valid_o,
  output logic                    busy_o
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
  localparam logic [3:0]       DMAX     = 4'(DIGIT_MAX);

  typedef enum logic {
    EDIT,
    HOLD
  } state_t;

  state_t     state;
  logic [4:0] btn_q;
  logic [4:0] press;
  logic [4:0] evt;
  logic [3:0] cur_digit;
  logic [3:0] inc_digit;
  logic [3:0] dec_digit;

  // A press is a rising edge seen against the previous sampled level.
  assign press = btn_i & ~btn_q;

`ifdef DIGIT_ENTRY_AUTOREPEAT_EN
  localparam int REPEAT_DELAY  = 50_000_000;
  localparam int REPEAT_PERIOD = 10_000_000;
  localparam int RPT_W         = $clog2(REPEAT_DELAY + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             held_inc;
  logic             held_dec;
  logic             rpt_fire;

  assign held_inc = btn_i[2] & btn_q[2];
  assign held_dec = btn_i[3] & btn_q[3];

  // rpt_cnt is the number of held cycles since the press, minus one.
  // After a repeat fires, the counter is rewound so that the next repeat
  // comes REPEAT_PERIOD cycles later.
  assign rpt_fire = (state == EDIT) && (held_inc || held_dec) &&
                    (rpt_cnt == RPT_W'(REPEAT_DELAY - 1));

  always_ff @(posedge clk) begin
    if (rst || (state != EDIT) || (press != 5'b0) || !(held_inc || held_dec)) begin
      rpt_cnt <= '0;
    end else if (rpt_fire) begin
      rpt_cnt <= RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    end else begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end

  // If both inc and dec are held, inc repeats, because the lower index
  // wins, as it does for simultaneous presses.
  assign evt = press | {1'b0, rpt_fire & held_dec & ~held_inc,
                        rpt_fire & held_inc, 2'b00};
`else
  assign evt = press;
`endif

  // Select the digit under the cursor and precompute its edited values.
  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel_o == SEL_W'(k)) begin
        cur_digit = data_o[4*k +: 4];
      end
    end
  end

  always_comb begin
    inc_digit = cur_digit + 4'd1;
    if (cur_digit >= DMAX) begin
      inc_digit = (WRAP != 0) ? 4'd0 : cur_digit;
    end
  end

  always_comb begin
    dec_digit = cur_digit - 4'd1;
    if (cur_digit == 4'd0) begin
      dec_digit = (WRAP != 0) ? DMAX : 4'd0;
    end
  end

  // Main control FSM. Only the lowest-index event acts; the rest are
  // dropped. In HOLD, every press is discarded. btn_q keeps tracking the
  // buttons, so a button held through HOLD does not fire on return to EDIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EDIT;
      btn_q    <= '0;
      data_o   <= '0;
      sel_o    <= '0;
      commit_o <= '0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      btn_q <= btn_i;
      case (state)
        EDIT: begin
          if (evt[0]) begin
            sel_o <= (sel_o == SEL_LAST) ? '0 : sel_o + SEL_W'(1);
          end else if (evt[1]) begin
            sel_o <= (sel_o == '0) ? SEL_LAST : sel_o - SEL_W'(1);
          end else if (evt[2]) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
              if (sel_o == SEL_W'(k)) begin
                data_o[4*k +: 4] <= inc_digit;
              end
            end
          end else if (evt[3]) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
              if (sel_o == SEL_W'(k)) begin
                data_o[4*k +: 4] <= dec_digit;
              end
            end
          end else if (evt[4]) begin
            commit_o <= data_o;
            valid_o  <= 1'b1;
            busy_o   <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (valid_o && ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            state   <= EDIT;
            if (CLEAR_ON_COMMIT != 0) begin
              data_o <= '0;
              sel_o  <= '0;
            end
          end
        end
        default: begin
          state <= EDIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_digit_entry_ctrl
//
// Directed testbench for digit_entry_ctrl. Two instances share the clock and
// reset:
//   dut       8 digits, DIGIT_MAX 9, saturating, clear on commit
//   dut_wrap  8 digits, DIGIT_MAX 9, wrapping,   keep value on commit
// Inputs change on the falling edge. Outputs are sampled on the falling edge
// after the rising edge that acted on them.
// ---------------------------------------------------------------------------
module tb_digit_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btn0;
  logic [4:0]  btn1;
  logic        ready;

  logic [31:0] data0, commit0, data1, commit1;
  logic [2:0]  sel0, sel1;
  logic        valid0, busy0, valid1, busy1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  digit_entry_ctrl #(
    .NUM_DIGITS(8), .DIGIT_MAX(9), .WRAP(0), .CLEAR_ON_COMMIT(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_i(btn0), .ready_i(ready),
    .data_o(data0), .sel_o(sel0), .commit_o(commit0),
    .valid_o(valid0), .busy_o(busy0)
  );

  digit_entry_ctrl #(
    .NUM_DIGITS(8), .DIGIT_MAX(9), .WRAP(1), .CLEAR_ON_COMMIT(0)
  ) dut_wrap (
    .clk(clk), .rst(rst), .btn_i(btn1), .ready_i(ready),
    .data_o(data1), .sel_o(sel1), .commit_o(commit1),
    .valid_o(valid1), .busy_o(busy1)
  );

  // Compare one observed value with its expected value, and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a button pattern for cycles rising edges, then release it.
  // The task returns on a falling edge, so outputs can be checked at once.
  task automatic applyStimulus(input logic [4:0] b, input bit to_wrap,
                               input int cycles);
    @(negedge clk);
    if (to_wrap) btn1 = b;
    else         btn0 = b;
    repeat (cycles) @(negedge clk);
    btn0 = 5'b0;
    btn1 = 5'b0;
  endtask

  task automatic pulses(input logic [4:0] b, input bit to_wrap, input int n);
    for (int i = 0; i < n; i++) applyStimulus(b, to_wrap, 1);
  endtask

  initial begin
    rst   = 1'b1;
    btn0  = 5'b0;
    btn1  = 5'b0;
    ready = 1'b0;

    // Reset held for two edges, then released.
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst data",   data0,   32'h0);
    checkOutput("rst sel",    32'(sel0), 32'h0);
    checkOutput("rst commit", commit0, 32'h0);
    checkOutput("rst valid",  32'(valid0), 32'h0);
    checkOutput("rst busy",   32'(busy0), 32'h0);
    checkOutput("rst wrap data", data1, 32'h0);

    // Saturating increment and decrement.
    pulses(5'b00100, 0, 12);
    checkOutput("sat inc", data0, 32'h00000009);
    pulses(5'b01000, 0, 1);
    checkOutput("dec", data0, 32'h00000008);
    applyStimulus(5'b01000, 0, 4);
    checkOutput("held dec single", data0, 32'h00000007);

    // Wrapping instance.
    pulses(5'b01000, 1, 1);
    checkOutput("wrap dec", data1, 32'h00000009);
    pulses(5'b00100, 1, 1);
    checkOutput("wrap inc", data1, 32'h00000000);
    pulses(5'b00100, 1, 1);
    checkOutput("wrap inc2", data1, 32'h00000001);

    // Cursor wrap in both directions.
    pulses(5'b00010, 0, 1);
    checkOutput("sel right wrap", 32'(sel0), 32'd7);
    pulses(5'b00001, 0, 1);
    checkOutput("sel left wrap", 32'(sel0), 32'd0);

    // digit0 = 2, digit3 = 4.
    pulses(5'b01000, 0, 5);
    pulses(5'b00001, 0, 3);
    checkOutput("sel 3", 32'(sel0), 32'd3);
    pulses(5'b00100, 0, 4);
    checkOutput("data 4002", data0, 32'h00004002);

    // Simultaneous presses: the lowest index wins.
    pulses(5'b00010, 0, 3);
    applyStimulus(5'b00101, 0, 1);
    checkOutput("simul sel", 32'(sel0), 32'd1);
    checkOutput("simul data", data0, 32'h00004002);
    applyStimulus(5'b01100, 0, 1);
    checkOutput("inc beats dec", data0, 32'h00004012);
    applyStimulus(5'b10010, 0, 1);
    checkOutput("right beats enter sel", 32'(sel0), 32'd0);
    checkOutput("right beats enter busy", 32'(busy0), 32'h0);

    // Build 0x1234.
    pulses(5'b00100, 0, 2);
    pulses(5'b00001, 0, 1);
    pulses(5'b00100, 0, 2);
    pulses(5'b00001, 0, 1);
    pulses(5'b00100, 0, 2);
    pulses(5'b00001, 0, 1);
    pulses(5'b01000, 0, 3);
    checkOutput("data 1234", data0, 32'h00001234);

    // Enter with ready low: HOLD keeps the commit valid and ignores buttons.
    applyStimulus(5'b10000, 0, 1);
    checkOutput("enter valid", 32'(valid0), 32'h1);
    checkOutput("enter busy", 32'(busy0), 32'h1);
    checkOutput("enter commit", commit0, 32'h00001234);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold valid", 32'(valid0), 32'h1);
      checkOutput("hold commit", commit0, 32'h00001234);
    end
    applyStimulus(5'b00100, 0, 1);
    checkOutput("hold inc ignored", data0, 32'h00001234);
    checkOutput("hold sel frozen", 32'(sel0), 32'd3);

    // Handshake clears the instance that has CLEAR_ON_COMMIT = 1.
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checkOutput("hs valid", 32'(valid0), 32'h0);
    checkOutput("hs busy", 32'(busy0), 32'h0);
    checkOutput("hs data clear", data0, 32'h0);
    checkOutput("hs sel clear", 32'(sel0), 32'd0);
    checkOutput("hs commit kept", commit0, 32'h00001234);

    // Wrap instance has CLEAR_ON_COMMIT = 0. ready is already high at enter.
    ready = 1'b1;
    applyStimulus(5'b10000, 1, 1);
    checkOutput("w enter valid", 32'(valid1), 32'h1);
    checkOutput("w commit", commit1, 32'h00000001);
    @(negedge clk);
    ready = 1'b0;
    checkOutput("w hs valid", 32'(valid1), 32'h0);
    checkOutput("w hs busy", 32'(busy1), 32'h0);
    checkOutput("w data kept", data1, 32'h00000001);
    checkOutput("ready no effect", 32'(valid0), 32'h0);

    // Reset during HOLD drops the pending commit.
    pulses(5'b00100, 0, 1);
    applyStimulus(5'b10000, 0, 1);
    checkOutput("pre-rst commit", commit0, 32'h00000001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst hold valid", 32'(valid0), 32'h0);
    checkOutput("rst hold busy", 32'(busy0), 32'h0);
    checkOutput("rst hold commit", commit0, 32'h0);
    pulses(5'b00100, 0, 1);
    checkOutput("edit after rst", data0, 32'h00000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/digit_entry_ctrl.md
Name: digit_entry_ctrl

Overview:
- Parametrised button-driven numeric entry controller for the ATM front panel (PIN and amount entry).
- Takes debounced button levels and edits a packed BCD register one digit at a time under a cursor.
- Hands the committed value to downstream logic over a valid/ready handshake.
- Fully synchronous to one clock; button edges are detected inside the block, and buttons are never used as clocks.

Parameters:
- NUM_DIGITS, 8: number of 4-bit digits, legal range 1..16.
- DIGIT_MAX, 9: largest legal digit value, legal range 1..15.
- WRAP, 0: 0 = increment/decrement saturate at DIGIT_MAX/0; 1 = wrap DIGIT_MAX<->0.
- CLEAR_ON_COMMIT, 1: 1 = all digits and the cursor clear when a handshake completes; 0 = they keep their values.
- SEL_W, $clog2(NUM_DIGITS) with a minimum of 1: cursor width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_i  in  5  debounced button levels: [0] cursor left (toward MSD), [1] cursor right, [2] increment, [3] decrement, [4] enter
- ready_i  in  1  downstream accepts the committed value
- data_o  out  4*NUM_DIGITS  live edit register, digit k at [4k+3:4k]
- sel_o  out  SEL_W  cursor position; 0 = least-significant digit
- commit_o  out  4*NUM_DIGITS  value captured on enter
- valid_o  out  1  commit_o is valid
- busy_o  out  1  high in HOLD state

Behaviour:
- Reset values:
  - data_o = 0, sel_o = 0, commit_o = 0, valid_o = 0, busy_o = 0.
  - State = EDIT; edge-detect history = 0.
  - On rst, any in-flight commit is dropped.
- Edge detect:
  - One registered copy of btn_i; press = btn_i & ~btn_q.
  - Only rising edges act. A held level produces exactly one event, except under the optional feature.
- Simultaneous presses in the same cycle: the lowest-index press wins and the rest are discarded, not queued.
- State EDIT:
  - press[0]: sel <= (sel == NUM_DIGITS-1) ? 0 : sel+1.
  - press[1]: sel <= (sel == 0) ? NUM_DIGITS-1 : sel-1.
  - press[2]: only digit[sel] changes; other digits are untouched.
    - If digit == DIGIT_MAX: WRAP=0 holds the value; WRAP=1 sets it to 0.
    - Otherwise +1.
  - press[3]: only digit[sel] changes; other digits are untouched.
    - If digit == 0: WRAP=0 holds the value; WRAP=1 sets it to DIGIT_MAX.
    - Otherwise -1.
  - press[4]: commit_o <= data_o; valid_o <= 1; go to HOLD.
- State HOLD (busy_o = 1):
  - All button presses are ignored and discarded; data_o, sel_o and commit_o are frozen.
  - valid_o stays high until ready_i is seen high on a clock edge.
  - On valid_o & ready_i:
    - valid_o <= 0; go to EDIT in the same cycle.
    - If CLEAR_ON_COMMIT=1: data_o <= 0, sel_o <= 0.
  - ready_i while valid_o = 0 has no effect.
- Latency:
  - A button edge at cycle N (btn_i first sampled high) updates the outputs at edge N+1.
  - Enter sets valid_o at N+1.
  - A handshake at edge M drops valid_o after M.
- Out-of-range digit values (>DIGIT_MAX) cannot occur by construction. A DIGIT_MAX < 15 with WRAP=0 never produces digits above DIGIT_MAX.
- NUM_DIGITS = 1: sel_o is constant 0; cursor presses are consumed with no effect.

Optional Feature:
- Macro: DIGIT_ENTRY_AUTOREPEAT_EN.
- Defined:
  - Localparams REPEAT_DELAY = 50_000_000 and REPEAT_PERIOD = 10_000_000 (cycles).
  - When btn_i[2] or btn_i[3] is held continuously in EDIT after its initial press, a repeat event is generated REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
  - A repeat event is treated exactly like a new press of that button, with the same priority rules.
  - Release, any other button level going high, entering HOLD, or rst clears the repeat counter.
  - The counter is sized to hold REPEAT_DELAY.
- Undefined: no repeat logic or counter is built; held buttons produce a single event.

Test Plan:
- rst held 2 cycles, then released -> data_o = 0, sel_o = 0, valid_o = 0, busy_o = 0 on the first clock after release.
- NUM_DIGITS=8, WRAP=0, sel = 0, 12 separate pulses on btn_i[2] -> digit0 = 9, data_o = 32'h00000009. Then one btn_i[3] pulse -> 32'h00000008.
- WRAP=1: at digit0 = 0, one btn_i[3] pulse -> digit0 = 9. Then one btn_i[2] pulse -> digit0 = 0.
- From sel = 0, btn_i[1] pulse -> sel_o = 7. Then btn_i[0] pulse -> sel_o = 0. Set digit3 to 4 and digit0 to 2 -> data_o = 32'h00004002.
- btn_i = 5'b00101 rising in one cycle -> only the cursor moves (sel 0 -> 1); digit unchanged.
- data_o = 32'h00001234, enter pulse with ready_i = 0 for 5 cycles -> valid_o = 1 and commit_o = 32'h00001234 throughout.
  - A btn_i[2] pulse during HOLD is ignored.
  - Then ready_i = 1 for one cycle -> valid_o = 0 on the next cycle; CLEAR_ON_COMMIT=1 gives data_o = 0 and sel_o = 0.
  - rst asserted during HOLD -> valid_o = 0 and state returns to EDIT.
